// File: rtl/rtlola_event_scheduler.sv
// rtl/rtlola_event_scheduler.sv - event capture queue and layered evaluation sequencer
//
// Purpose: every enabled cycle that carries a stream strobe or a periodic tick
// is captured as one record into a small FIFO. A two-state sequencer pops one
// record at a time and presents it to the evaluator for LAYERS handshakes.
//
// Ports:
//   clk, rst (sync, active-high), en (clock enable / full freeze)
//   input_0/1, new_input_0/1   : stream values and event strobes
//   eval_ready                 : evaluator accepts the current layer
//   ev_valid, ev_layer         : layer request and its index
//   ev_input_0/1, ev_new_0/1,
//   ev_periodic, ev_timestamp  : fields of the record under evaluation
//   q_push, q_push_valid       : capture request / accepted into FIFO
//   q_pop, q_pop_valid         : dequeue request / record taken
//   overflow                   : sticky, a record was dropped on a full FIFO
module rtlola_event_scheduler #(
  parameter int DATA_W = 64,
  parameter int TS_W   = 32,
  parameter int PERIOD = 500,
  parameter int DEPTH  = 4,
  parameter int LAYERS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [DATA_W-1:0]                             input_0,
  input  logic                                          new_input_0,
  input  logic [DATA_W-1:0]                             input_1,
  input  logic                                          new_input_1,
  input  logic                                          eval_ready,
  output logic                                          ev_valid,
  output logic [((LAYERS > 1) ? $clog2(LAYERS) : 1)-1:0] ev_layer,
  output logic [DATA_W-1:0]                             ev_input_0,
  output logic [DATA_W-1:0]                             ev_input_1,
  output logic                                          ev_new_0,
  output logic                                          ev_new_1,
  output logic                                          ev_periodic,
  output logic [TS_W-1:0]                               ev_timestamp,
  output logic                                          q_push,
  output logic                                          q_pop,
  output logic                                          q_push_valid,
  output logic                                          q_pop_valid,
  output logic                                          overflow
);

  localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int PW    = $clog2(PERIOD);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 2 * DATA_W + 3 + TS_W;

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [TS_W-1:0]     ts_q;
  logic [PW-1:0]       per_q;
  logic                tick;
  logic [LW-1:0]       layer_q;
  logic                ovf_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [REC_W-1:0]    mem_q [DEPTH];
  logic [REC_W-1:0]    rec_in, head;
  logic                full, empty;

  logic [DATA_W-1:0]   ev_in0_q, ev_in1_q;
  logic                ev_new0_q, ev_new1_q, ev_per_q;
  logic [TS_W-1:0]     ev_ts_q;

  assign tick   = (per_q == PW'(PERIOD - 1));
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign rec_in = {input_0, input_1, new_input_0, new_input_1, tick, ts_q};
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  // Full is judged on the pre-pop occupancy, so a push into a full FIFO is
  // dropped even if a pop frees a slot in the same cycle.
  assign q_push       = en && !rst && (new_input_0 || new_input_1 || tick);
  assign q_push_valid = q_push && !full;
  assign q_pop_valid  = q_pop && !empty;
  assign overflow     = ovf_q;

  assign ev_input_0   = ev_in0_q;
  assign ev_input_1   = ev_in1_q;
  assign ev_new_0     = ev_new0_q;
  assign ev_new_1     = ev_new1_q;
  assign ev_periodic  = ev_per_q;
  assign ev_timestamp = ev_ts_q;

  // Timestamp and period counters advance together, so the first tick lands
  // at timestamp PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q  <= '0;
      per_q <= '0;
    end else if (en) begin
      ts_q  <= ts_q + TS_W'(1);
      per_q <= tick ? '0 : per_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (q_push_valid) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (q_push_valid) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (q_pop_valid)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (q_push && full) ovf_q <= 1'b1;
    end
  end

  // Record under evaluation and layer index.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_in0_q  <= '0;
      ev_in1_q  <= '0;
      ev_new0_q <= 1'b0;
      ev_new1_q <= 1'b0;
      ev_per_q  <= 1'b0;
      ev_ts_q   <= '0;
      layer_q   <= '0;
    end else if (q_pop_valid) begin
      ev_in0_q  <= head[REC_W-1 -: DATA_W];
      ev_in1_q  <= head[REC_W-DATA_W-1 -: DATA_W];
      ev_new0_q <= head[TS_W+2];
      ev_new1_q <= head[TS_W+1];
      ev_per_q  <= head[TS_W];
      ev_ts_q   <= head[TS_W-1:0];
      layer_q   <= '0;
    end else if (en && state_q == EVAL && eval_ready) begin
      layer_q <= (layer_q == LW'(LAYERS - 1)) ? '0 : layer_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (q_pop_valid) state_d = EVAL;
    end else begin
      if (en && eval_ready && layer_q == LW'(LAYERS - 1)) state_d = IDLE;
    end
  end

  always_comb begin
    q_pop    = 1'b0;
    ev_valid = 1'b0;
    ev_layer = '0;
    if (state_q == EVAL) begin
      ev_valid = 1'b1;
      ev_layer = layer_q;
    end else if (en && !rst) begin
      q_pop = 1'b1;
    end
  end

endmodule

// File: doc/rtlola_event_scheduler.md
RTLOLA_EVENT_SCHEDULER -- requirements
Module: rtlola_event_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 64, signed width of each input stream value.
REQ-002 SHALL have parameter TS_W, default 32, timestamp width.
REQ-003 SHALL have parameter PERIOD, default 500, periodic-tick interval in enabled cycles (>=2).
REQ-004 SHALL have parameter DEPTH, default 4, event FIFO depth in records (power of 2).
REQ-005 SHALL have parameter LAYERS, default 3, number of evaluation layers per event (>=1).
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset; en  in  1  clock enable.
REQ-007 SHALL have ports: input_0  in  DATA_W  stream 0 value; new_input_0  in  1  stream 0 event strobe; input_1  in  DATA_W  stream 1 value; new_input_1  in  1  stream 1 event strobe.
REQ-008 SHALL have port eval_ready  in  1  downstream accepts the current layer.
REQ-009 SHALL have ports: ev_valid  out  1  layer request valid; ev_layer  out  clog2(LAYERS)  current layer index; ev_input_0, ev_input_1  out  DATA_W  captured values; ev_new_0, ev_new_1  out  1  captured strobes; ev_periodic  out  1  record includes periodic tick; ev_timestamp  out  TS_W  capture time.
REQ-010 SHALL have ports: q_push, q_pop, q_push_valid, q_pop_valid  out  1  FIFO strobes; overflow  out  1  sticky drop flag.
REQ-011 SHALL have one clock, clk; reset is rst, synchronous and active-high.

Function
REQ-012 SHALL treat en=0 as a full freeze: no counter advance, no push, no pop, no FSM change; strobe outputs 0.
REQ-013 SHALL keep timestamp counter incremented once per enabled cycle, wrapping modulo 2^TS_W.
REQ-014 SHALL keep period counter 0..PERIOD-1; tick asserted in the enabled cycle where it equals PERIOD-1, then wraps to 0 (first tick at timestamp PERIOD-1).
REQ-015 SHALL assert q_push combinationally in any enabled cycle with new_input_0, new_input_1 or tick; the cycle forms ONE record {input_0, input_1, new_input_0, new_input_1, tick, timestamp}.
REQ-016 SHALL set q_push_valid = q_push & !full, with full evaluated before any same-cycle pop; write at the end of that cycle.
REQ-017 SHALL drop the record when q_push & full and set overflow=1, held until reset.
REQ-018 SHALL use FSM states IDLE and EVAL; reset state IDLE.
REQ-019 In IDLE, SHALL assert q_pop; q_pop_valid = q_pop & !empty; on q_pop_valid load head into ev_* registers, set layer=0, go to EVAL.
REQ-020 In EVAL, SHALL hold ev_valid=1 with stable ev_* outputs; on eval_ready: if layer==LAYERS-1 go to IDLE, else increment layer.
REQ-021 SHALL give minimum latency: strobe in cycle t -> q_pop_valid in t+1 -> ev_valid from t+2 with layer 0.
REQ-022 SHALL never pop during EVAL; an event occupies >= LAYERS+1 cycles of pop bandwidth.
REQ-023 SHALL keep ev_valid=0 and ev_layer=0 in IDLE; ev_* data holds last loaded record.
REQ-024 SHALL handle simultaneous push and pop: both take effect; occupancy unchanged.

Reset
REQ-025 On rst=1 at a clock edge (regardless of en), SHALL clear both counters, empty FIFO, clear overflow, enter IDLE, and zero every ev_* output.
REQ-026 SHALL drive all strobe outputs 0 while rst=1.
REQ-027 On reset mid-EVAL, SHALL abandon the current event; ev_valid=0 the next cycle; no record survives.
REQ-028 SHALL start the first post-reset enabled cycle at timestamp 0.

Verification
REQ-029 Reset: rst=1 for 3 cycles with strobes active -> all outputs 0, overflow=0, no q_push.
REQ-030 Single event: new_input_0=1, input_0=5 at timestamp 10, eval_ready=1 -> q_push_valid at 10, q_pop_valid at 11, ev_valid at 12,13,14 with layer 0,1,2, ev_input_0=5, ev_new_0=1, ev_new_1=0, ev_periodic=0, ev_timestamp=10.
REQ-031 Coincidence: new_input_0=new_input_1=1, values 3 and 4, at timestamp 499 -> one record with ev_periodic=1, both new flags 1, timestamp 499; next tick at 999.
REQ-032 Overflow: eval_ready=0, events on 6 consecutive cycles -> first held in EVAL, 4 queued, 6th has q_push=1, q_push_valid=0, overflow=1 thereafter.
REQ-033 Enable freeze: en=0 for 10 cycles with new_input_1=1 -> no q_push, timestamp frozen, first tick delayed by 10 cycles to timestamp 499 at wall cycle 509.
REQ-034 Reset mid-eval: rst at layer 1 with 2 records queued -> next cycle ev_valid=0, q_pop_valid=0, timestamp 0.
